fixed_point_neuron_mac: RTL and testbench
=========================================

# fixed_point_neuron_mac

Streaming multiply-accumulate stage that computes one neuron pre-activation, sum(x_i·w_i) + bias over N_INPUTS signed Q(INTEGER.FRACTION) operand pairs. The result is rescaled and saturated back to DATA_WIDTH. It sits directly upstream of fixed_point_tanh / fixed_point_sigmoid and drives their `in` port. Its valid/ready output also qualifies their enable.

## Interface
- DATA_WIDTH, 12, total operand/result width (signed two's complement)
- INTEGER, 6, integer bits including sign
- FRACTION, 6, fraction bits; INTEGER+FRACTION == DATA_WIDTH
- N_INPUTS, 4, products per neuron (>=1)
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage accepts operand pair
- in_x  input  DATA_WIDTH  activation operand, Q6.6
- in_w  input  DATA_WIDTH  weight operand, Q6.6
- bias  input  DATA_WIDTH  bias, Q6.6; sampled with the first beat of each neuron
- out_valid  output  1  result valid; drives activation enable
- out_ready  input  1  downstream accepts result
- out_data  output  DATA_WIDTH  saturated Q6.6 pre-activation

## Operation
- FSM states: S_ACC (collecting beats), S_OUT (holding result).
- Beat = in_valid && in_ready. in_ready = (state == S_ACC).
- Product: full-precision signed DATA_WIDTH×DATA_WIDTH → 2·DATA_WIDTH bits, Q(2·INTEGER).(2·FRACTION).
- Accumulator width ACC_W = 2·DATA_WIDTH + clog2(N_INPUTS) + 1. It never overflows internally.
- First beat (count == 0): acc <= product + (bias sign-extended, shifted left by FRACTION). Other beats: acc <= acc + product.
- count increments per beat and wraps to 0 on the beat where count == N_INPUTS-1. That beat moves the FSM to S_OUT.
- On entering S_OUT, out_data is registered from the final accumulator: rescale arithmetic right by FRACTION (rounding per Configuration), then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- S_OUT: out_valid = 1, out_data stable. On out_valid && out_ready the FSM returns to S_ACC.
- in_valid low in S_ACC: no state change. Partial accumulation is held indefinitely.

## Timing
- Reset values: state S_ACC, count 0, acc 0, out_valid 0, out_data 0, in_ready 1 (the cycle after reset deasserts).
- Latency: final beat accepted in cycle t → out_valid = 1 in cycle t+1.
- Throughput: one beat per cycle. One bubble per neuron, since in_ready is low while in S_OUT.
- Output handshake in cycle u → in_ready = 1 in cycle u+1. No beat is accepted in cycle u itself.
- Backpressure: out_data and out_valid are held unchanged while out_ready = 0.
- Reset asserted mid-neuron or in S_OUT: all state returns to reset values on that edge. The partial result is discarded and no out_valid is produced.
- N_INPUTS = 1: every beat is both first and last.

## Configuration
- MAC_ROUND_EN defined: 2^(FRACTION-1) is added to the accumulator before the right shift (round half toward +inf), then the result is saturated.
- MAC_ROUND_EN undefined: plain arithmetic right shift (floor), then saturate. No extra adder is built.

## Structure
- Shared package fixed_point_pkg holds:
  - Q-format constants (DATA_WIDTH/INTEGER/FRACTION defaults)
  - clog2-based ACC_W function
  - FSM state enum
  - FP_MAX/FP_MIN saturation constants
  These are also used by the sigmoid/tanh blocks.
- One sub-module: fixed_point_saturate (ACC_W → DATA_WIDTH rescale, optional rounding, clamp). It is combinational and reusable by other MAC-type stages.

## Test plan
- N=4; x=64 (1.0), w=32 (0.5) ×4, bias=0 → out_data=128 (2.0), out_valid exactly one cycle after the 4th beat.
- x=1984 (31.0), w=1984 ×4, bias=0 → out_data=0x7FF. Negating w gives 0x800.
- x={1,0,0,0}, w=32, bias=0 → out_data=0 without MAC_ROUND_EN, 1 with it. x={-1(0xFFF),0,0,0} → 0xFFF without, 0 with.
- bias=64, all x=0 → out_data=64. Bias is changed mid-neuron after the first beat → no effect on out_data.
- out_ready held low 3 cycles in S_OUT → out_data/out_valid stable, in_ready=0, in_valid beats ignored. Release → in_ready=1 the next cycle.
- rst_n low after 2 of 4 beats → out_valid stays 0. The next 4 fresh beats (64×32) yield 128, with no residue from the aborted neuron.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared Q-format constants, accumulator sizing, FSM state type and saturation
// bounds for the fixed-point neuron datapath (MAC, sigmoid, tanh).
package fixed_point_pkg;

  localparam int unsigned FP_DATA_WIDTH = 12;
  localparam int unsigned FP_INTEGER    = 6;
  localparam int unsigned FP_FRACTION   = 6;

  localparam logic signed [FP_DATA_WIDTH-1:0] FP_MAX = {1'b0, {(FP_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [FP_DATA_WIDTH-1:0] FP_MIN = {1'b1, {(FP_DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    S_ACC,
    S_OUT
  } mac_state_t;

  // Full-precision product width plus growth for n_inputs terms and the bias term.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned n_inputs);
    return 2 * data_w + $clog2(n_inputs) + 1;
  endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Combinational rescale (arithmetic right shift by FRACTION) and clamp of a wide
// accumulator to OUT_W bits. Define MAC_ROUND_EN for round-half-up instead of floor.
module fixed_point_saturate #(
  parameter int unsigned IN_W     = 27,
  parameter int unsigned OUT_W    = 12,
  parameter int unsigned FRACTION = 6
) (
  input  logic [IN_W-1:0]  in_acc,
  output logic [OUT_W-1:0] out_sat
);

  localparam logic signed [IN_W-1:0] MAX_EXT = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_EXT = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] rounded;
  logic signed [IN_W-1:0] shifted;

`ifdef MAC_ROUND_EN
  localparam logic signed [IN_W-1:0] HALF = {{(IN_W-1){1'b0}}, 1'b1} << (FRACTION - 1);
  assign rounded = $signed(in_acc) + HALF;
`else
  assign rounded = $signed(in_acc);
`endif

  assign shifted = rounded >>> FRACTION;

  always_comb begin
    out_sat = shifted[OUT_W-1:0];
    if (shifted > MAX_EXT) begin
      out_sat = MAX_EXT[OUT_W-1:0];
    end else if (shifted < MIN_EXT) begin
      out_sat = MIN_EXT[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_neuron_mac.sv
// Streaming signed Q(INTEGER.FRACTION) multiply-accumulate: sum(x*w) + bias over
// N_INPUTS beats, rescaled and saturated to DATA_WIDTH. Rounding via MAC_ROUND_EN.
module fixed_point_neuron_mac
  import fixed_point_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FP_DATA_WIDTH,
  parameter int unsigned INTEGER    = FP_INTEGER,
  parameter int unsigned FRACTION   = FP_FRACTION,
  parameter int unsigned N_INPUTS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_w,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned PROD_W = 2 * (INTEGER + FRACTION);
  localparam int unsigned ACC_W  = acc_w(DATA_WIDTH, N_INPUTS);
  localparam int unsigned CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

  mac_state_t state;
  logic [CNT_W-1:0] count;
  logic signed [ACC_W-1:0] acc;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] w_ext;
  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  product_ext;
  logic signed [ACC_W-1:0]  bias_term;
  logic signed [ACC_W-1:0]  acc_next;
  logic [DATA_WIDTH-1:0]    sat_data;

  // Operands widened before the multiply so the product is full precision.
  assign x_ext       = {{(PROD_W-DATA_WIDTH){in_x[DATA_WIDTH-1]}}, in_x};
  assign w_ext       = {{(PROD_W-DATA_WIDTH){in_w[DATA_WIDTH-1]}}, in_w};
  assign product     = x_ext * w_ext;
  assign product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign bias_term   = $signed({{(ACC_W-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}) <<< FRACTION;
  assign acc_next    = (count == '0) ? product_ext + bias_term : acc + product_ext;

  assign in_ready = (state == S_ACC);

  fixed_point_saturate #(
    .IN_W     (ACC_W),
    .OUT_W    (DATA_WIDTH),
    .FRACTION (FRACTION)
  ) u_saturate (
    .in_acc  (acc_next),
    .out_sat (sat_data)
  );

  // Result is taken from acc_next so out_valid follows the final beat by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ACC;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            acc <= acc_next;
            if (count == LAST) begin
              count     <= '0;
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= sat_data;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_ACC;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_neuron_mac.sv
// Scoreboard bench for fixed_point_neuron_mac (N_INPUTS=4, Q6.6); honours MAC_ROUND_EN.
module tb_fixed_point_neuron_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_x = '0;
  logic [11:0] in_w = '0;
  logic [11:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;

  int checks = 0;
  int failures = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  fixed_point_neuron_mac #(
    .DATA_WIDTH (12),
    .INTEGER    (6),
    .FRACTION   (6),
    .N_INPUTS   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [11:0] model(input logic [3:0][11:0] xs, input logic [3:0][11:0] ws,
                                        input logic [11:0] b);
    longint s;
    s = longint'($signed(b)) * 64;
    for (int i = 0; i < 4; i++) s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
`ifdef MAC_ROUND_EN
    s += 32;
`endif
    s = s >>> 6;
    if (s > 2047) s = 2047;
    else if (s < -2048) s = -2048;
    return s[11:0];
  endfunction

  // Called at a negedge; returns at the negedge following the last accepted beat.
  task automatic drive_neuron(input logic [3:0][11:0] xs, input logic [3:0][11:0] ws,
                              input logic [11:0] b0, input logic [11:0] b_late, output bit to);
    to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
      if (!in_ready) to = 1'b1;
      in_valid = 1'b1;
      in_x = xs[i];
      in_w = ws[i];
      bias = (i == 0) ? b0 : b_late;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [11:0] d, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    d = out_valid ? out_data : 'x;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 12'h000) begin failures++; $display("FAIL reset_out_data: got %h expected 000", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [11:0] d, e; int lat; bit to;
    sb.push_back(12'd128);
    drive_neuron({4{12'd64}}, {4{12'd32}}, 12'd0, 12'd0, to);
    wait_out(d, lat);
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL basic_data: got %h expected %h", d, e); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL basic_latency: got %0d extra cycles expected 0", lat); end
    consume();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_handshake: got ready=%b valid=%b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_saturate();
    logic [11:0] d, e; int lat; bit to;
    sb.push_back(12'h7FF);
    drive_neuron({4{12'd1984}}, {4{12'd1984}}, 12'd0, 12'd0, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL sat_pos: got %h expected %h", d, e); end
    sb.push_back(12'h800);
    drive_neuron({4{12'd1984}}, {4{12'h840}}, 12'd0, 12'd0, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL sat_neg: got %h expected %h", d, e); end
  endtask

  task automatic test_rounding();
    logic [11:0] d, e; int lat; bit to;
`ifdef MAC_ROUND_EN
    sb.push_back(12'h001);
`else
    sb.push_back(12'h000);
`endif
    drive_neuron({12'd0, 12'd0, 12'd0, 12'd1}, {4{12'd32}}, 12'd0, 12'd0, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL round_pos_half: got %h expected %h", d, e); end
`ifdef MAC_ROUND_EN
    sb.push_back(12'h000);
`else
    sb.push_back(12'hFFF);
`endif
    drive_neuron({12'd0, 12'd0, 12'd0, 12'hFFF}, {4{12'd32}}, 12'd0, 12'd0, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL round_neg_half: got %h expected %h", d, e); end
  endtask

  task automatic test_bias();
    logic [11:0] d, e; int lat; bit to;
    sb.push_back(12'd64);
    drive_neuron({4{12'd0}}, {4{12'd0}}, 12'd64, 12'd64, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL bias_only: got %h expected %h", d, e); end
    sb.push_back(model({4{12'd64}}, {4{12'd32}}, 12'd64));
    drive_neuron({4{12'd64}}, {4{12'd32}}, 12'd64, 12'h500, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL bias_first_beat_only: got %h expected %h", d, e); end
  endtask

  task automatic test_backpressure();
    logic [11:0] d, e; int lat; bit to; bit stable;
    sb.push_back(model({12'd10, 12'd20, 12'hFF0, 12'd100}, {12'd7, 12'hFFD, 12'd64, 12'd50}, 12'd3));
    drive_neuron({12'd10, 12'd20, 12'hFF0, 12'd100}, {12'd7, 12'hFFD, 12'd64, 12'd50}, 12'd3, 12'd0, to);
    wait_out(d, lat);
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL bp_data: got %h expected %h", d, e); end
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = 12'd1984; in_w = 12'd1984;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL bp_hold: got valid=%b data=%h ready=%b expected 1 %h 0", out_valid, out_data, in_ready, e); end
    // Beat offered during the handshake cycle itself must not be taken.
    consume();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", in_ready, out_valid); end
    sb.push_back(12'd128);
    drive_neuron({4{12'd64}}, {4{12'd32}}, 12'd0, 12'd0, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL bp_no_residue: got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] d, e; int lat; bit to; bit seen;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_x = 12'd1984; in_w = 12'd1984; bias = 12'd500;
      @(negedge clk);
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rstmid_no_valid: got 1 expected 0"); end
    sb.push_back(12'd128);
    drive_neuron({4{12'd64}}, {4{12'd32}}, 12'd0, 12'd0, to);
    wait_out(d, lat); consume();
    e = sb.pop_front();
    checks++; if (to || d !== e) begin failures++; $display("FAIL rstmid_fresh: got %h expected %h", d, e); end
    drive_neuron({4{12'd64}}, {4{12'd32}}, 12'd0, 12'd0, to);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_data !== 12'h000) begin failures++; $display("FAIL rst_in_out: got valid=%b data=%h expected 0 000", out_valid, out_data); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d, e; int lat; bit to;
    logic [3:0][11:0] xs, ws; logic [11:0] b;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = 12'($urandom);
        ws[i] = 12'($urandom);
      end
      b = 12'($urandom);
      if (n < 5) begin
        xs = {12'($urandom_range(0, 255)), 12'($urandom_range(0, 255)), 12'($urandom_range(0, 255)), 12'($urandom_range(0, 255))};
        ws = {12'($urandom_range(0, 127)) - 12'd64, 12'($urandom_range(0, 127)) - 12'd64, 12'($urandom_range(0, 127)), 12'($urandom_range(0, 127))};
      end
      sb.push_back(model(xs, ws, b));
      drive_neuron(xs, ws, b, 12'($urandom), to);
      wait_out(d, lat);
      e = sb.pop_front();
      checks++; if (to || lat !== 0 || d !== e) begin failures++; $display("FAIL b2b_%0d: got %h lat=%0d expected %h lat=0", n, d, lat, e); end
      consume();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturate();
    test_rounding();
    test_bias();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_empty: got %0d entries expected 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
